dmem_arbiter: RTL

Single-port arbiter sharing the 8-bit data memory between the processor core's load/store path and a host port used for preloading operands and reading back results. It sits between the core and `data_mem`, driving the memory's read/write enables, address and write data. It grants one requester per cycle with core priority, a starvation guard for the host, and a host lock for uninterrupted bursts. Read data returns through a registered path one cycle after grant.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/arb_wait_ctr.sv | 32 +++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int CONFLICT_W = 16;

  // Counter width for a saturating count up to max_wait; never narrower than 1 bit.
  function automatic int wait_cnt_w(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating starvation counter: counts consecutive denied host cycles up to MAX_WAIT.
module arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = wait_cnt_w(MAX_WAIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic             at_max,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (inc && (r_cnt != MAX_V))
      r_cnt <= r_cnt + 1'b1;
  end

  assign at_max = (r_cnt == MAX_V);
  assign cnt    = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory with host burst lock.
// Optional contention statistics are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CONFLICT_W-1:0] conflict_cnt
`endif
);

  localparam int CNT_W = wait_cnt_w(MAX_WAIT);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             w_core_gnt;
  logic             w_host_gnt;
  logic             w_at_max;
  logic [CNT_W-1:0] w_wait_cnt;
  logic             r_core_rvalid;
  logic             r_host_rvalid;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait (
    .clk    (clk),
    .rst    (reset),
    .inc    (host_req & ~w_host_gnt),
    .clr    (~host_req | w_host_gnt),
    .at_max (w_at_max),
    .cnt    (w_wait_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ARB_NORMAL;
    else
      r_state <= w_state_nxt;
  end

  // Grants are suppressed outright while reset is high, so nothing reaches memory.
  always_comb begin
    w_core_gnt  = 1'b0;
    w_host_gnt  = 1'b0;
    w_state_nxt = r_state;
    if (!reset) begin
      if ((r_state == ARB_LOCKED) && host_req && host_lock)
        w_host_gnt = 1'b1;
      else if (host_req && (!core_req || w_at_max))
        w_host_gnt = 1'b1;
      else if (core_req)
        w_core_gnt = 1'b1;
      w_state_nxt = (w_host_gnt && host_lock) ? ARB_LOCKED : ARB_NORMAL;
    end
  end

  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (w_core_gnt) begin
      mem_read_en  = ~core_we;
      mem_write_en = core_we;
      mem_addr     = core_addr;
      mem_wdata    = core_wdata;
    end else if (w_host_gnt) begin
      mem_read_en  = ~host_we;
      mem_write_en = host_we;
      mem_addr     = host_addr;
      mem_wdata    = host_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_core_rdata  <= '0;
      r_host_rdata  <= '0;
    end else begin
      r_core_rvalid <= w_core_gnt & ~core_we;
      r_host_rvalid <= w_host_gnt & ~host_we;
      if (w_core_gnt && !core_we)
        r_core_rdata <= mem_rdata;
      if (w_host_gnt && !host_we)
        r_host_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CONFLICT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_conflict_cnt <= '0;
    else if (core_req && host_req && (r_conflict_cnt != '1))
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

  assign core_gnt    = w_core_gnt;
  assign host_gnt    = w_host_gnt;
  assign core_rvalid = r_core_rvalid;
  assign host_rvalid = r_host_rvalid;
  assign core_rdata  = r_core_rdata;
  assign host_rdata  = r_host_rdata;

endmodule
